handshake_constant_seq: RTL and testbench



---
 rtl/handshake_pkg.sv | 15 +
 rtl/handshake_skid_buffer.sv | 60 ++++++
 rtl/handshake_constant_seq.sv | 90 +++++++++
 tb/tb_handshake_constant_seq.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/handshake_pkg.sv
`default_nettype none
// ============================================================================
// Module  : handshake_pkg
// Purpose : Shared helpers for the elastic handshake units.
// Revision: 1.0 - initial release
// ============================================================================
package handshake_pkg;

    // Counter width for a sequence of `count` entries; never narrower than 1.
    function automatic int idx_width(input int count);
        return (count <= 1) ? 1 : $clog2(count);
    endfunction

endpackage
`default_nettype wire

// File: rtl/handshake_skid_buffer.sv
`default_nettype none
// ============================================================================
// Module  : handshake_skid_buffer
// Purpose : Generic 2-slot elastic register, valid/ready on both sides,
//           with a fully registered in_ready.
// Revision: 1.0 - initial release
// ============================================================================
module handshake_skid_buffer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    logic             r_main_valid;
    logic             r_skid_valid;
    logic [WIDTH-1:0] r_main_data;
    logic [WIDTH-1:0] r_skid_data;
    logic             w_in_fire;
    logic             w_main_free;

    assign w_in_fire   = in_valid & ~r_skid_valid;
    assign w_main_free = ~r_main_valid | out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_main_valid <= 1'b0;
            r_skid_valid <= 1'b0;
            r_main_data  <= '0;
            r_skid_data  <= '0;
        end else if (w_main_free) begin
            // Skid holds the older token, so it always takes priority for main.
            if (r_skid_valid) begin
                r_main_data  <= r_skid_data;
                r_main_valid <= 1'b1;
                r_skid_valid <= 1'b0;
            end else if (w_in_fire) begin
                r_main_data  <= in_data;
                r_main_valid <= 1'b1;
            end else begin
                r_main_valid <= 1'b0;
            end
        end else if (w_in_fire) begin
            r_skid_data  <= in_data;
            r_skid_valid <= 1'b1;
        end
    end

    assign in_ready  = ~r_skid_valid;
    assign out_valid = r_main_valid;
    assign out_data  = r_main_data;

endmodule
`default_nettype wire

// File: rtl/handshake_constant_seq.sv
`default_nettype none
// ============================================================================
// Module  : handshake_constant_seq
// Purpose : Elastic token source emitting BASE, BASE+STEP, ... (COUNT entries,
//           then wrap) for every accepted ctrl token, through a skid buffer.
// Revision: 1.0 - initial release
// ============================================================================
module handshake_constant_seq
    import handshake_pkg::*;
#(
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] BASE       = '0,
    parameter logic [DATA_WIDTH-1:0] STEP       = DATA_WIDTH'(1),
    parameter int                    COUNT      = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ctrl_valid,
    output logic                  ctrl_ready,
    output logic [DATA_WIDTH-1:0] outs,
    output logic                  outs_valid,
    input  logic                  outs_ready,
    output logic                  outs_last
);

    localparam int             IDX_W      = idx_width(COUNT);
    localparam logic [IDX_W-1:0] c_LAST_IDX = IDX_W'(COUNT - 1);

    generate
        if (COUNT < 1) begin : g_bad_count
            $error("handshake_constant_seq: COUNT must be >= 1");
        end
    endgenerate

    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic                  last;
    } token_t;

    logic [IDX_W-1:0]      r_index;
    logic [DATA_WIDTH-1:0] r_acc;
    logic                  w_buf_ready;
    logic                  w_ctrl_fire;
    logic                  w_is_last;
    token_t                w_in_token;
    token_t                w_out_token;

    // The buffer's ready is already registered; masking with rst keeps the
    // unit closed for the whole reset interval.
    assign ctrl_ready  = w_buf_ready & ~rst;
    assign w_ctrl_fire = ctrl_valid & ctrl_ready;
    assign w_is_last   = (r_index == c_LAST_IDX);

    assign w_in_token.data = r_acc;
    assign w_in_token.last = w_is_last;

    // Running accumulator instead of BASE + index*STEP: one adder, no multiplier.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_index <= '0;
            r_acc   <= BASE;
        end else if (w_ctrl_fire) begin
            if (w_is_last) begin
                r_index <= '0;
                r_acc   <= BASE;
            end else begin
                r_index <= r_index + IDX_W'(1);
                r_acc   <= r_acc + STEP;
            end
        end
    end

    handshake_skid_buffer #(
        .WIDTH (DATA_WIDTH + 1)
    ) u_buf (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (ctrl_valid),
        .in_ready  (w_buf_ready),
        .in_data   (w_in_token),
        .out_valid (outs_valid),
        .out_ready (outs_ready),
        .out_data  (w_out_token)
    );

    assign outs      = w_out_token.data;
    assign outs_last = w_out_token.last;

endmodule
`default_nettype wire

// File: tb/tb_handshake_constant_seq.sv
`default_nettype none
// ============================================================================
// Module  : tb_handshake_constant_seq
// Purpose : Self-checking bench; four configurations share one stimulus and
//           one scoreboard queue of expected tokens.
// Revision: 1.0 - initial release
// ============================================================================
module tb_handshake_constant_seq;

    localparam int N  = 4;
    localparam int DW = 12;
    localparam logic [DW-1:0] P_BASE  [N] = '{12'hFAF, 12'hFFE, 12'h000, 12'hFAF};
    localparam logic [DW-1:0] P_STEP  [N] = '{12'd3, 12'd1, 12'hFFF, 12'd5};
    localparam int            P_COUNT [N] = '{4, 4, 3, 1};

    localparam logic [DW-1:0] SEQ [N][5] = '{
        '{12'hFAF, 12'hFB2, 12'hFB5, 12'hFB8, 12'hFAF},
        '{12'hFFE, 12'hFFF, 12'h000, 12'h001, 12'hFFE},
        '{12'h000, 12'hFFF, 12'hFFE, 12'h000, 12'hFFF},
        '{12'hFAF, 12'hFAF, 12'hFAF, 12'hFAF, 12'hFAF}
    };
    localparam logic [4:0] SEQ_LAST [N] = '{5'b01000, 5'b01000, 5'b00100, 5'b11111};

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ctrl_valid = 1'b0;
    logic outs_ready = 1'b0;
    logic [N-1:0]  ctrl_ready_w;
    logic [N-1:0]  outs_valid_w;
    logic [N-1:0]  outs_last_w;
    logic [DW-1:0] outs_w [N];

    generate
        for (genvar g = 0; g < N; g++) begin : g_dut
            handshake_constant_seq #(
                .DATA_WIDTH (DW),
                .BASE       (P_BASE[g]),
                .STEP       (P_STEP[g]),
                .COUNT      (P_COUNT[g])
            ) dut (
                .clk        (clk),
                .rst        (rst),
                .ctrl_valid (ctrl_valid),
                .ctrl_ready (ctrl_ready_w[g]),
                .outs       (outs_w[g]),
                .outs_valid (outs_valid_w[g]),
                .outs_ready (outs_ready),
                .outs_last  (outs_last_w[g])
            );
        end
    endgenerate

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct packed {
        logic [N-1:0][DW-1:0] d;
        logic [N-1:0]         l;
    } exp_t;

    exp_t    sbq [$];
    exp_t    e;
    int      m_idx [N];
    bit      mon_en = 0;
    bit      hs_chk = 0;
    bit      exp_ready;
    bit      m_in_fire = 0;
    bit      m_out_fire = 0;
    bit      last_fire = 0;
    bit      r_pend = 0;
    bit      prev_stall [N];
    logic [DW-1:0] prev_outs [N];
    int      n_push = 0;
    int      n_dut_out = 0;

    function automatic logic [DW-1:0] exp_val(input int k, input int idx);
        logic [31:0] p;
        p = 32'(idx) * 32'(P_STEP[k]) + 32'(P_BASE[k]);
        return p[DW-1:0];
    endfunction

    // Scoreboard: the queue is exactly the set of tokens the DUT should hold.
    always @(negedge clk) begin
        if (mon_en) begin
            exp_ready = !rst && (sbq.size() < 2);
            for (int k = 0; k < N; k++) begin
                n_tests++;
                if (ctrl_ready_w[k] !== exp_ready) begin
                    n_fail++;
                    $display("FAIL sb_ctrl_ready dut%0d t=%0t: got %b want %b", k, $time, ctrl_ready_w[k], exp_ready);
                end
                n_tests++;
                if (outs_valid_w[k] !== (sbq.size() > 0)) begin
                    n_fail++;
                    $display("FAIL sb_outs_valid dut%0d t=%0t: got %b want %b", k, $time, outs_valid_w[k], sbq.size() > 0);
                end
                if (sbq.size() > 0) begin
                    n_tests++;
                    if ({outs_w[k], outs_last_w[k]} !== {sbq[0].d[k], sbq[0].l[k]}) begin
                        n_fail++;
                        $display("FAIL sb_token dut%0d t=%0t: got %h/%b want %h/%b", k, $time, outs_w[k], outs_last_w[k], sbq[0].d[k], sbq[0].l[k]);
                    end
                end
                if (prev_stall[k]) begin
                    n_tests++;
                    if (outs_w[k] !== prev_outs[k]) begin
                        n_fail++;
                        $display("FAIL stall_stable dut%0d t=%0t: got %h want %h", k, $time, outs_w[k], prev_outs[k]);
                    end
                end
                prev_stall[k] = outs_valid_w[k] && !outs_ready && !rst;
                prev_outs[k]  = outs_w[k];
            end
            if (hs_chk && r_pend)
                assert (ctrl_valid) else $error("bench dropped ctrl_valid before handshake");
            r_pend     = ctrl_valid && !exp_ready && !rst;
            m_in_fire  = ctrl_valid && exp_ready;
            m_out_fire = (sbq.size() > 0) && outs_ready && !rst;
            if (outs_valid_w[0] && outs_ready && !rst)
                n_dut_out++;
        end
    end

    always @(posedge clk) begin
        if (mon_en) begin
            if (rst) begin
                sbq.delete();
                for (int k = 0; k < N; k++) m_idx[k] = 0;
                last_fire = 0;
            end else begin
                if (m_out_fire) void'(sbq.pop_front());
                if (m_in_fire) begin
                    for (int k = 0; k < N; k++) begin
                        e.d[k]   = exp_val(k, m_idx[k]);
                        e.l[k]   = (m_idx[k] == P_COUNT[k] - 1);
                        m_idx[k] = (m_idx[k] == P_COUNT[k] - 1) ? 0 : m_idx[k] + 1;
                    end
                    sbq.push_back(e);
                    n_push++;
                end
                last_fire = m_in_fire;
            end
        end
    end

    task automatic do_reset(input int n);
        @(posedge clk);
        #1 rst = 1'b1; ctrl_valid = 1'b0; outs_ready = 1'b0;
        repeat (n) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; ctrl_valid = 1'b1; outs_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 mon_en = 1;
        @(negedge clk);
        for (int k = 0; k < N; k++) begin
            n_tests++;
            if ({ctrl_ready_w[k], outs_valid_w[k], outs_last_w[k], outs_w[k]} !== {3'b000, 12'h000}) begin
                n_fail++;
                $display("FAIL reset_state dut%0d: got rdy=%b vld=%b last=%b outs=%h want 0/0/0/000",
                         k, ctrl_ready_w[k], outs_valid_w[k], outs_last_w[k], outs_w[k]);
            end
        end
        @(posedge clk);
        #1 rst = 1'b0; ctrl_valid = 1'b0;
        @(negedge clk);
        for (int k = 0; k < N; k++) begin
            n_tests++;
            if (ctrl_ready_w[k] !== 1'b1) begin
                n_fail++;
                $display("FAIL ready_after_reset dut%0d: got %b want 1", k, ctrl_ready_w[k]);
            end
        end
    endtask

    task automatic test_stream;
        do_reset(1);
        @(posedge clk);
        #1 ctrl_valid = 1'b1; outs_ready = 1'b1;
        @(negedge clk);
        for (int k = 0; k < N; k++) begin
            n_tests++;
            if (outs_valid_w[k] !== 1'b0) begin
                n_fail++;
                $display("FAIL stream_latency dut%0d: got valid %b want 0", k, outs_valid_w[k]);
            end
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            for (int k = 0; k < N; k++) begin
                n_tests++;
                if ({outs_valid_w[k], outs_w[k], outs_last_w[k]} !== {1'b1, SEQ[k][i], SEQ_LAST[k][i]}) begin
                    n_fail++;
                    $display("FAIL stream_seq dut%0d i=%0d: got v=%b %h last=%b want v=1 %h last=%b",
                             k, i, outs_valid_w[k], outs_w[k], outs_last_w[k], SEQ[k][i], SEQ_LAST[k][i]);
                end
            end
        end
        @(posedge clk);
        #1 ctrl_valid = 1'b0;
        repeat (3) @(posedge clk);
    endtask

    task automatic test_backpressure;
        int acc;
        do_reset(1);
        @(posedge clk);
        #1 ctrl_valid = 1'b1; outs_ready = 1'b0;
        acc = 0;
        repeat (6) begin
            @(negedge clk);
            if (ctrl_valid && ctrl_ready_w[0]) acc++;
        end
        n_tests++;
        if (acc != 2) begin
            n_fail++;
            $display("FAIL bp_accepted: got %0d want 2", acc);
        end
        for (int k = 0; k < N; k++) begin
            n_tests++;
            if ({ctrl_ready_w[k], outs_valid_w[k], outs_w[k]} !== {2'b01, SEQ[k][0]}) begin
                n_fail++;
                $display("FAIL bp_full dut%0d: got rdy=%b vld=%b %h want 0/1 %h",
                         k, ctrl_ready_w[k], outs_valid_w[k], outs_w[k], SEQ[k][0]);
            end
        end
        @(posedge clk);
        #1 outs_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            for (int k = 0; k < N; k++) begin
                n_tests++;
                if ({outs_valid_w[k], outs_w[k]} !== {1'b1, SEQ[k][i]}) begin
                    n_fail++;
                    $display("FAIL bp_drain dut%0d i=%0d: got v=%b %h want v=1 %h", k, i, outs_valid_w[k], outs_w[k], SEQ[k][i]);
                end
            end
        end
        @(posedge clk);
        #1 ctrl_valid = 1'b0;
        repeat (3) @(posedge clk);
    endtask

    task automatic test_reset_mid;
        do_reset(1);
        @(posedge clk);
        #1 ctrl_valid = 1'b1; outs_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 outs_ready = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        for (int k = 0; k < N; k++) begin
            n_tests++;
            if (outs_valid_w[k] !== 1'b0) begin
                n_fail++;
                $display("FAIL midrst_flush dut%0d: got valid %b want 0", k, outs_valid_w[k]);
            end
        end
        @(negedge clk);
        for (int k = 0; k < N; k++) begin
            n_tests++;
            if ({outs_valid_w[k], outs_w[k], outs_last_w[k]} !== {1'b1, P_BASE[k], P_COUNT[k] == 1}) begin
                n_fail++;
                $display("FAIL midrst_restart dut%0d: got v=%b %h last=%b want v=1 %h last=%b",
                         k, outs_valid_w[k], outs_w[k], outs_last_w[k], P_BASE[k], P_COUNT[k] == 1);
            end
        end
        @(posedge clk);
        #1 ctrl_valid = 1'b0; outs_ready = 1'b1;
        repeat (4) @(posedge clk);
    endtask

    task automatic test_random;
        int push0;
        int out0;
        do_reset(1);
        hs_chk = 1;
        push0  = n_push;
        out0   = n_dut_out;
        for (int c = 0; c < 10000; c++) begin
            @(posedge clk);
            #1;
            if (!(ctrl_valid && !last_fire)) ctrl_valid = ($urandom_range(0, 99) < 60);
            outs_ready = ($urandom_range(0, 99) < 55);
        end
        for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            #1;
            if (!(ctrl_valid && !last_fire)) ctrl_valid = 1'b0;
            outs_ready = 1'b1;
        end
        @(negedge clk);
        n_tests++;
        if (sbq.size() != 0 || outs_valid_w !== '0) begin
            n_fail++;
            $display("FAIL rand_drain: got queue=%0d valid=%b want 0/0000", sbq.size(), outs_valid_w);
        end
        n_tests++;
        if ((n_dut_out - out0) != (n_push - push0)) begin
            n_fail++;
            $display("FAIL rand_count: got %0d tokens out want %0d", n_dut_out - out0, n_push - push0);
        end
        hs_chk = 0;
    endtask

    initial begin
        for (int k = 0; k < N; k++) begin
            m_idx[k]      = 0;
            prev_stall[k] = 0;
            prev_outs[k]  = '0;
        end
        test_reset;
        test_stream;
        test_backpressure;
        test_reset_mid;
        test_random;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
